// File: rtl/alu_sum_accumulator.sv
// alu_sum_accumulator
// Sums a programmed number of adder results arriving on a valid/ready
// stream into a wider running total. Presents the total and a sticky
// carry-out flag on a valid/ready result handshake.

module alu_sum_accumulator #(
    parameter int IN_W  = 4,
    parameter int ACC_W = 6,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Zero-extension width that lifts an input beat to the sum width.
    localparam int EXT_W = ACC_W + 1 - IN_W;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_cnt;

    state_t             w_state_nxt;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic               w_ovf_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [ACC_W:0]     w_sum;
    logic               w_in_fire;
    logic               w_out_fire;

    // Carry-preserving sum of one beat with the running total.
    function automatic logic [ACC_W:0] beat_sum(
        input logic [ACC_W-1:0] acc,
        input logic [IN_W-1:0]  beat
    );
        beat_sum = {1'b0, acc} + {{EXT_W{1'b0}}, beat};
    endfunction

    // Handshake qualifiers and the candidate sum for this cycle.
    always_comb begin
        w_in_fire  = in_valid && (r_state == ST_ACCUM);
        w_out_fire = out_ready && (r_state == ST_DONE);
        w_sum      = beat_sum(r_acc, in_data);
    end

    // Next-state and datapath update decode.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_ovf_nxt   = r_ovf;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_acc_nxt = {ACC_W{1'b0}};
                    w_ovf_nxt = 1'b0;
                    w_cnt_nxt = len;
                    if (len != {CNT_W{1'b0}}) begin
                        w_state_nxt = ST_ACCUM;
                    end else begin
                        // Empty run: present the cleared total right away.
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (w_in_fire) begin
                    w_acc_nxt = w_sum[ACC_W-1:0];
                    w_ovf_nxt = r_ovf | w_sum[ACC_W];
                    w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    if (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ACCUM;
                    end
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_DONE: begin
                // Result stays put until the consumer takes it.
                if (w_out_fire) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_acc_nxt   = {ACC_W{1'b0}};
                w_ovf_nxt   = 1'b0;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= {ACC_W{1'b0}};
            r_ovf   <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_ovf   <= w_ovf_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs decode straight from registers so they carry no input paths.
    always_comb begin
        in_ready  = (r_state == ST_ACCUM);
        out_valid = (r_state == ST_DONE);
        busy      = (r_state != ST_IDLE);
        out_data  = r_acc;
        out_ovf   = r_ovf;
    end

endmodule
